univ_shift_reg: RTL and testbench
=================================

# univ_shift_reg

Parametrised universal shift register, the successor to the fixed 8-bit `shift` block. It adds a configurable width, a serial input and a bidirectional burst-shift engine. A burst shifts N positions, one per clock, with busy/done handshaking and a parallel load that overrides any burst. The block sits in the `dsd` datapath library as the common serialiser/deserialiser primitive.

## Interface
- `WIDTH`, 8: register width in bits (≥2).
- `CW`, `$clog2(WIDTH+1)`: width of the shift-count input (derived; do not override).
- `clk` in 1: sole clock, rising edge.
- `rstn` in 1: reset, synchronous and active-low.
- `load` in 1: parallel load of `LD` at the next edge.
- `LD` in WIDTH: parallel load data.
- `dir` in 1: 0 = shift toward the MSB (left), 1 = shift toward the LSB (right). Latched at start.
- `sin` in 1: serial fill bit, sampled on every shift edge.
- `rot` in 1: rotate request, latched at start. Only honoured when the rotate feature is compiled in.
- `start` in 1: request a burst.
- `cnt` in CW: number of positions to shift in the burst. Latched at start.
- `q` out WIDTH: register contents.
- `cout` out 1: the bit shifted out by the most recent shift. Holds its value otherwise.
- `busy` out 1: a burst is in progress.
- `done` out 1: one-cycle pulse when a burst completes.

## Operation
- **Reset** (`rstn`=0 at an edge): `q`=0, `cout`=0, `busy`=0, `done`=0, FSM enters IDLE, and internal count and latched controls clear. Reset overrides every other input, including in the middle of a burst.
- **Priority** at each edge: reset, then load, then start.
- **FSM states:** IDLE and SHIFT. `done` is a registered pulse and is not a state.
- **IDLE:**
  - `load`=1: `q`←`LD`; `cout` is unchanged.
  - Otherwise, `start`=1 with `cnt`≠0: latch `cnt`, `dir` and `rot`; go to SHIFT; `busy`=1.
  - `start`=1 with `cnt`=0: stay in IDLE, pulse `done`, leave `q` unchanged.
- **SHIFT:** each edge performs one shift and decrements the remaining count.
  - Left: `q`←{`q[WIDTH-2:0]`, fill}, `cout`←`q[WIDTH-1]`.
  - Right: `q`←{fill, `q[WIDTH-1:1]`}, `cout`←`q[0]`.
  - fill = `sin`, or the outgoing bit when rotating.
  - On the edge that performs the last shift: go to IDLE, `busy`←0, `done`←1.
- **Load during SHIFT:** the burst aborts. `q`←`LD`, go to IDLE, `busy`←0, and no `done` pulse is issued.
- **Start during SHIFT** is ignored. A new start is accepted only in IDLE, which includes the cycle in which `done`=1.
- **Count range:** `cnt` may exceed WIDTH (up to 2^CW−1). Shifting simply continues, and surplus shifts fill from `sin` or rotate.
- **Input sampling:** `dir`, `rot` and `cnt` changes during a burst have no effect. `sin` is live.

## Timing
- `start` accepted at edge k with `cnt`=N≥1:
  - `busy`=1 after edge k.
  - Shifts occur at edges k+1 … k+N.
  - `busy`=0 and `done`=1 after edge k+N.
  - `done`=0 after edge k+N+1.
  - Total latency from the start edge to `done` is N cycles.
- `start` with `cnt`=0 at edge k: `done`=1 after edge k and `busy` never rises.
- `load` takes effect in one cycle (`q` valid after the load edge).
- All outputs are registered, with no combinational input-to-output paths.

## Configuration
- **`SHIFT_ROTATE_EN` defined:** when `rot` is latched as 1, the fill bit equals the bit leaving the register (circular shift). `cout` still reports that bit.
- **`SHIFT_ROTATE_EN` undefined:** the rotate logic is absent and `rot` is ignored (treated as 0); fill is always `sin`. The port remains present in both builds.

## Structure
- **Package `shift_pkg`:**
  - State enum `shift_state_t` (IDLE, SHIFT).
  - Direction localparams `DIR_LEFT`=0 and `DIR_RIGHT`=1.
- **Sub-module `shift_burst_cnt`:** loadable down-counter of width CW. It takes `load_cnt` and `dec` as inputs and outputs `last` (remaining count = 1) and `zero`. The FSM and the data register stay in the top module.

## Test plan
All scenarios use WIDTH=8.
- **Reset:** hold `rstn`=0 for 2 edges → `q`=00, `cout`=0, `busy`=0, `done`=0; also apply reset mid-burst and check the same values.
- **Left burst:** load 55; start `cnt`=3, `dir`=0, `sin`=0 → `q` goes AA, 54, A8; `cout` goes 0, 1, 0; `busy` is high for 3 cycles; `done` pulses once after the 3rd shift.
- **Right burst:** load AA; start `cnt`=2, `dir`=1, `sin`=1 → `q` goes D5, EA; `cout` goes 0, 1; `done` is asserted for one cycle.
- **Abort by load:** start `cnt`=5, then assert `load` with `LD`=FF on the 2nd busy cycle → `q`=FF, `busy`=0 on the next cycle, and `done` never pulses.
- **Zero count and ignored start:** start with `cnt`=0 → `done` next cycle, `q` unchanged, `busy`=0. Then start `cnt`=4, with a second start while busy → exactly 4 shifts and a single `done`.
- **Rotate:** load 81; start `cnt`=1, `dir`=0, `rot`=1, `sin`=0 → with `SHIFT_ROTATE_EN`, `q`=03 and `cout`=1; without it, `q`=02 and `cout`=1.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared types for the universal shift register: FSM state and direction encodings.
package shift_pkg;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } shift_state_t;

   localparam logic DIR_LEFT  = 1'b0;
   localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/shift_burst_cnt.sv
// Loadable down-counter tracking the shifts remaining in a burst.
module shift_burst_cnt #(
   parameter int CW = 4
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          load_cnt,
   input  logic          dec,
   input  logic [CW-1:0] cnt_i,
   output logic          last,
   output logic          zero
);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_cnt)
         cnt_d = cnt_i;
      else if (dec && (cnt_q != '0))
         cnt_d = cnt_q - 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rstn) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   assign last = (cnt_q == CW'(1));
   assign zero = (cnt_q == '0);

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register with N-position burst shifts, busy/done handshake and
// load override. Define SHIFT_ROTATE_EN to compile in circular (rotate) shifting.
module univ_shift_reg
   import shift_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CW    = $clog2(WIDTH+1)
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             load,
   input  logic [WIDTH-1:0] LD,
   input  logic             dir,
   input  logic             sin,
   input  logic             rot,
   input  logic             start,
   input  logic [CW-1:0]    cnt,
   output logic [WIDTH-1:0] q,
   output logic             cout,
   output logic             busy,
   output logic             done
);

   shift_state_t     state_q, state_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic             cout_q, cout_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             dir_q, dir_d;
   logic             load_cnt, dec, cnt_last, cnt_zero;
   logic [CW-1:0]    cnt_val;
   logic             out_bit, fill;

   assign out_bit = (dir_q == DIR_RIGHT) ? q_q[0] : q_q[WIDTH-1];

`ifdef SHIFT_ROTATE_EN
   logic rot_q, rot_d;
   assign fill = rot_q ? out_bit : sin;
`else
   logic unused_rot;
   assign unused_rot = rot;
   assign fill       = sin;
`endif

   always_comb begin
      state_d  = state_q;
      q_d      = q_q;
      cout_d   = cout_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      dir_d    = dir_q;
`ifdef SHIFT_ROTATE_EN
      rot_d    = rot_q;
`endif
      load_cnt = 1'b0;
      dec      = 1'b0;
      cnt_val  = cnt;
      // Load wins over everything; an aborted burst also flushes the counter.
      if (load) begin
         q_d      = LD;
         state_d  = IDLE;
         busy_d   = 1'b0;
         load_cnt = 1'b1;
         cnt_val  = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  if (cnt != '0) begin
                     state_d  = SHIFT;
                     busy_d   = 1'b1;
                     load_cnt = 1'b1;
                     dir_d    = dir;
`ifdef SHIFT_ROTATE_EN
                     rot_d    = rot;
`endif
                  end else begin
                     done_d = 1'b1;
                  end
               end
            end
            SHIFT: begin
               dec    = 1'b1;
               cout_d = out_bit;
               q_d    = (dir_q == DIR_RIGHT) ? {fill, q_q[WIDTH-1:1]}
                                             : {q_q[WIDTH-2:0], fill};
               if (cnt_last || cnt_zero) begin
                  state_d = IDLE;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q <= IDLE;
         q_q     <= '0;
         cout_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         dir_q   <= 1'b0;
`ifdef SHIFT_ROTATE_EN
         rot_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         q_q     <= q_d;
         cout_q  <= cout_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         dir_q   <= dir_d;
`ifdef SHIFT_ROTATE_EN
         rot_q   <= rot_d;
`endif
      end
   end

   shift_burst_cnt #(.CW(CW)) u_cnt (
      .clk      (clk),
      .rstn     (rstn),
      .load_cnt (load_cnt),
      .dec      (dec),
      .cnt_i    (cnt_val),
      .last     (cnt_last),
      .zero     (cnt_zero)
   );

   assign q    = q_q;
   assign cout = cout_q;
   assign busy = busy_q;
   assign done = done_q;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed bench for univ_shift_reg: arithmetic reference model checked every cycle
// plus hand-computed expectations at key points of each scenario.
module tb_univ_shift_reg;

   localparam int W  = 8;
   localparam int CW = $clog2(W+1);

   logic          clk = 1'b0;
   logic          rstn, load, dir, sin, rot, start;
   logic [W-1:0]  LD;
   logic [CW-1:0] cnt;
   logic [W-1:0]  q;
   logic          cout, busy, done;

   univ_shift_reg #(.WIDTH(W)) dut (
      .clk(clk), .rstn(rstn), .load(load), .LD(LD), .dir(dir), .sin(sin),
      .rot(rot), .start(start), .cnt(cnt), .q(q), .cout(cout), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   int n_cmp  = 0;
   int n_fail = 0;

   // Reference model: plain integer arithmetic on the register value.
   int mq = 0, mcout = 0, mbusy = 0, mdone = 0, rem = 0, mdir = 0, mrot = 0, armed = 0;

   always @(posedge clk) begin
      int outb, fill;
      mdone = 0;
      if (!rstn) begin
         mq = 0; mcout = 0; mbusy = 0; rem = 0; mdir = 0; mrot = 0; armed = 1;
      end else if (load) begin
         mq = int'(LD); mbusy = 0; rem = 0;
      end else if (mbusy != 0) begin
         outb = (mdir != 0) ? (mq % 2) : ((mq / (1 << (W-1))) % 2);
`ifdef SHIFT_ROTATE_EN
         fill = (mrot != 0) ? outb : int'(sin);
`else
         fill = int'(sin);
`endif
         if (mdir != 0) mq = mq / 2 + fill * (1 << (W-1));
         else           mq = (mq * 2 + fill) % (1 << W);
         mcout = outb;
         rem   = rem - 1;
         if (rem == 0) begin mbusy = 0; mdone = 1; end
      end else if (start) begin
         if (cnt == 0) mdone = 1;
         else begin mbusy = 1; rem = int'(cnt); mdir = int'(dir); mrot = int'(rot); end
      end
   end

   // Hand-computed expectations posted by the stimulus (-1 = don't care).
   int e_q = -1, e_cout = -1, e_busy = -1, e_done = -1, e_seq = 0, seen = 0;

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (armed != 0) begin
         chk("model_q",    int'(q),    mq);
         chk("model_cout", int'(cout), mcout);
         chk("model_busy", int'(busy), mbusy);
         chk("model_done", int'(done), mdone);
      end
      if (e_seq != seen) begin
         seen = e_seq;
         if (e_q    >= 0) chk("lit_q",    int'(q),    e_q);
         if (e_cout >= 0) chk("lit_cout", int'(cout), e_cout);
         if (e_busy >= 0) chk("lit_busy", int'(busy), e_busy);
         if (e_done >= 0) chk("lit_done", int'(done), e_done);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_out(input int eq, input int ec, input int eb, input int ed);
      e_q = eq; e_cout = ec; e_busy = eb; e_done = ed;
      e_seq++;
   endtask

`ifdef SHIFT_ROTATE_EN
   localparam int ROT_Q = 'h03;
`else
   localparam int ROT_Q = 'h02;
`endif

   initial begin
      rstn = 1'b0; load = 1'b0; LD = '0; dir = 1'b0; sin = 1'b0; rot = 1'b0;
      start = 1'b0; cnt = '0;
      step(); step();
      expect_out(0, 0, 0, 0);
      rstn = 1'b1;

      // left burst
      load = 1'b1; LD = 8'h55; step(); load = 1'b0; expect_out('h55, 0, 0, 0);
      start = 1'b1; cnt = 3; dir = 1'b0; sin = 1'b0; step(); start = 1'b0;
      expect_out('h55, 0, 1, 0);
      step(); expect_out('hAA, 0, 1, 0);
      step(); expect_out('h54, 1, 1, 0);
      step(); expect_out('hA8, 0, 0, 1);
      step(); expect_out('hA8, 0, 0, 0);

      // right burst, dir/cnt changes mid-burst must not matter
      load = 1'b1; LD = 8'hAA; step(); load = 1'b0; expect_out('hAA, 0, 0, 0);
      start = 1'b1; cnt = 2; dir = 1'b1; sin = 1'b1; step(); start = 1'b0;
      dir = 1'b0; cnt = 7; expect_out('hAA, 0, 1, 0);
      step(); expect_out('hD5, 0, 1, 0);
      step(); expect_out('hEA, 1, 0, 1);
      step(); expect_out('hEA, 1, 0, 0);

      // abort by load on the second busy cycle
      start = 1'b1; cnt = 5; dir = 1'b0; sin = 1'b0; step(); start = 1'b0;
      expect_out('hEA, 1, 1, 0);
      step(); expect_out('hD4, 1, 1, 0);
      load = 1'b1; LD = 8'hFF; step(); load = 1'b0; expect_out('hFF, 1, 0, 0);
      step(); expect_out('hFF, 1, 0, 0);
      step(); expect_out('hFF, 1, 0, 0);

      // zero count, then a start ignored while busy
      start = 1'b1; cnt = 0; step(); start = 1'b0; expect_out('hFF, 1, 0, 1);
      step(); expect_out('hFF, 1, 0, 0);
      start = 1'b1; cnt = 4; dir = 1'b1; sin = 1'b0; step(); expect_out('hFF, 1, 1, 0);
      cnt = 2; step(); start = 1'b0; expect_out('h7F, 1, 1, 0);
      step(); expect_out('h3F, 1, 1, 0);
      step(); expect_out('h1F, 1, 1, 0);
      step(); expect_out('h0F, 1, 0, 1);
      step(); expect_out('h0F, 1, 0, 0);

      // rotate request
      load = 1'b1; LD = 8'h81; step(); load = 1'b0; expect_out('h81, 1, 0, 0);
      start = 1'b1; cnt = 1; dir = 1'b0; rot = 1'b1; sin = 1'b0; step();
      start = 1'b0; rot = 1'b0; expect_out('h81, 1, 1, 0);
      step(); expect_out(ROT_Q, 1, 0, 1);
      step(); expect_out(ROT_Q, 1, 0, 0);

      // count larger than the width, sin filling
      load = 1'b1; LD = 8'h01; step(); load = 1'b0; expect_out('h01, 1, 0, 0);
      start = 1'b1; cnt = 10; dir = 1'b0; sin = 1'b1; step(); start = 1'b0;
      dir = 1'b1; expect_out('h01, 1, 1, 0);
      step(); expect_out('h03, 0, 1, 0);
      repeat (8) step();
      step(); expect_out('hFF, 1, 0, 1);

      // reset in the middle of a burst
      start = 1'b1; cnt = 6; dir = 1'b0; sin = 1'b0; step(); start = 1'b0;
      expect_out('hFF, 1, 1, 0);
      step();
      rstn = 1'b0; step(); rstn = 1'b1; expect_out(0, 0, 0, 0);
      step(); expect_out(0, 0, 0, 0);
      step();

      @(negedge clk); #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
